// File: rtl/f1_pkg.sv
// f1_pkg: shared types and constants for the F1 race-start controller.
// Macro: F1_JUMP_START_EN enables the jump-start fault path in f1_start_ctrl.
package f1_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        HOLD,
        GO,
        TIMING,
        DONE,
        FLUSH
    } f1_state_t;

    localparam int N_LIGHTS_DEF = 8;

    // Feedback mask for a right-shifting Galois LFSR of width w.
    // Bit i-1 of the mask corresponds to term x^i of a primitive polynomial,
    // so every supported width cycles through all 2^w-1 nonzero values.
    function automatic logic [31:0] lfsr_taps(input int w);
        case (w)
            3:       return 32'h0000_0006;
            4:       return 32'h0000_000C;
            5:       return 32'h0000_0014;
            6:       return 32'h0000_0030;
            7:       return 32'h0000_0060;
            8:       return 32'h0000_00B8;
            9:       return 32'h0000_0110;
            10:      return 32'h0000_0240;
            11:      return 32'h0000_0500;
            12:      return 32'h0000_0E08;
            13:      return 32'h0000_1C80;
            14:      return 32'h0000_3802;
            15:      return 32'h0000_6000;
            16:      return 32'h0000_B400;
            default: return 32'h0000_0060;
        endcase
    endfunction

endpackage

// File: rtl/f1_lfsr.sv
// f1_lfsr: free-running maximal-length Galois LFSR used as the random hold source.
// The register advances every clock and never reaches zero from a nonzero seed.
module f1_lfsr
    import f1_pkg::*;
#(
    parameter int             W    = 7,
    parameter logic [W-1:0]   SEED = 7'h5A
) (
    input  logic         clk,
    input  logic         rst,
    output logic [W-1:0] q
);

    localparam logic [31:0]  TAPS_FULL = lfsr_taps(W);
    localparam logic [W-1:0] TAPS      = TAPS_FULL[W-1:0];

    // Shift right; when a one falls out of bit 0, fold the feedback mask back in.
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value regardless of the order the simulator runs processes.
    always_ff @(posedge clk) begin
        if (rst) q <= SEED;
        else     q <= {1'b0, q[W-1:1]} ^ (q[0] ? TAPS : '0);
    end

endmodule

// File: rtl/f1_start_ctrl.sv
// f1_start_ctrl: race-start sequencer. Steps the light FSM through N_LIGHTS
// lights, waits a pseudo-random hold, puts the lights out and then measures
// driver reaction time in ticks.
// Macro: F1_JUMP_START_EN adds the FLUSH state and the jump_start output.
module f1_start_ctrl
    import f1_pkg::*;
#(
    parameter int                  LFSR_W    = 7,
    parameter logic [LFSR_W-1:0]   LFSR_SEED = 7'h5A,
    parameter int                  TIME_W    = 16,
    parameter int                  N_LIGHTS  = N_LIGHTS_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              trigger,
    input  logic              tick,
    input  logic              react,
    output logic              light_en,
    output logic              busy,
    output logic              time_valid,
    output logic [TIME_W-1:0] react_time
`ifdef F1_JUMP_START_EN
    ,
    output logic              jump_start
`endif
);

    localparam int                CNT_W     = $clog2(N_LIGHTS + 1);
    localparam logic [CNT_W-1:0]  LAST      = CNT_W'(N_LIGHTS);
    localparam logic [TIME_W-1:0] TIME_MAX  = {TIME_W{1'b1}};
    localparam logic [LFSR_W-1:0] HOLD_LAST = LFSR_W'(1);

    f1_state_t         state, state_n;
    logic [CNT_W-1:0]  light_cnt, light_cnt_n;
    logic [LFSR_W-1:0] hold_cnt, hold_cnt_n;
    logic [TIME_W-1:0] timer, timer_n;
    logic [TIME_W-1:0] react_time_n;
    logic              time_valid_n;
    logic              trigger_q, react_q;
    logic              trig_rise, react_rise;
    logic [LFSR_W-1:0] lfsr;
`ifdef F1_JUMP_START_EN
    logic              jump_start_n;
`endif

    f1_lfsr #(
        .W    (LFSR_W),
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk (clk),
        .rst (rst),
        .q   (lfsr)
    );

    // Previous-cycle copies of the buttons for rising-edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            trigger_q <= 1'b0;
            react_q   <= 1'b0;
        end else begin
            trigger_q <= trigger;
            react_q   <= react;
        end
    end

    assign trig_rise  = trigger & ~trigger_q;
    assign react_rise = react & ~react_q;
    assign busy       = (state == ARMED) || (state == HOLD) || (state == GO) ||
                        (state == TIMING) || (state == FLUSH);

    // State and datapath registers; all next values come from the block below.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            light_cnt  <= '0;
            hold_cnt   <= '0;
            timer      <= '0;
            react_time <= '0;
            time_valid <= 1'b0;
`ifdef F1_JUMP_START_EN
            jump_start <= 1'b0;
`endif
        end else begin
            state      <= state_n;
            light_cnt  <= light_cnt_n;
            hold_cnt   <= hold_cnt_n;
            timer      <= timer_n;
            react_time <= react_time_n;
            time_valid <= time_valid_n;
`ifdef F1_JUMP_START_EN
            jump_start <= jump_start_n;
`endif
        end
    end

    // Next-state, datapath updates and the light_en advance pulse.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_n      = state;
        light_cnt_n  = light_cnt;
        hold_cnt_n   = hold_cnt;
        timer_n      = timer;
        react_time_n = react_time;
        time_valid_n = time_valid;
        light_en     = 1'b0;
`ifdef F1_JUMP_START_EN
        jump_start_n = jump_start;
`endif
        case (state)
            IDLE: begin
                if (trig_rise) begin
                    state_n = ARMED;
`ifdef F1_JUMP_START_EN
                    jump_start_n = 1'b0;
`endif
                end
            end
            ARMED: begin
`ifdef F1_JUMP_START_EN
                if (react_rise) begin
                    state_n      = FLUSH;
                    jump_start_n = 1'b1;
                end else
`endif
                if (tick) begin
                    light_en    = 1'b1;
                    light_cnt_n = light_cnt + 1'b1;
                    if (light_cnt_n == LAST) begin
                        hold_cnt_n = lfsr;
                        state_n    = HOLD;
                    end
                end
            end
            HOLD: begin
`ifdef F1_JUMP_START_EN
                if (react_rise) begin
                    state_n      = FLUSH;
                    jump_start_n = 1'b1;
                end else
`endif
                if (tick) begin
                    if (hold_cnt == HOLD_LAST) state_n = GO;
                    else                       hold_cnt_n = hold_cnt - 1'b1;
                end
            end
            GO: begin
                // Lights out: the light FSM wraps from N_LIGHTS back to all-off.
                light_en    = 1'b1;
                light_cnt_n = '0;
                timer_n     = '0;
                state_n     = TIMING;
            end
            TIMING: begin
                // A react edge wins over a coincident tick, so that tick is not counted.
                if (react_rise) begin
                    react_time_n = timer;
                    time_valid_n = 1'b1;
                    state_n      = DONE;
                end else if (tick && (timer != TIME_MAX)) begin
                    timer_n = timer + 1'b1;
                end
            end
            DONE: begin
                if (trig_rise) begin
                    time_valid_n = 1'b0;
                    state_n      = ARMED;
`ifdef F1_JUMP_START_EN
                    jump_start_n = 1'b0;
`endif
                end
            end
`ifdef F1_JUMP_START_EN
            FLUSH: begin
                // Step the light FSM forward every cycle until it wraps to all-off.
                time_valid_n = 1'b0;
                if (light_cnt == '0) begin
                    state_n = DONE;
                end else begin
                    light_en = 1'b1;
                    if (light_cnt == LAST) begin
                        light_cnt_n = '0;
                        state_n     = DONE;
                    end else begin
                        light_cnt_n = light_cnt + 1'b1;
                    end
                end
            end
`endif
            default: state_n = IDLE;
        endcase
    end

endmodule
